// File: rtl/jtdd_share_arb.sv
// Shared-RAM arbiter between the main CPU and the MCU, with an MCU halt handshake.
// Optional halt timeout enabled by defining JTDD_ARB_TOUT_EN.
module jtdd_share_arb #(
  parameter int AW   = 9,
  parameter int TOUT = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          cpu_cs,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  input  logic          mcu_cs,
  input  logic          mcu_we,
  input  logic [AW-1:0] mcu_addr,
  input  logic [7:0]    mcu_din,
  input  logic          halt_req,
  input  logic          mcu_ba,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_din,
  output logic          ram_we,
  output logic          cpu_ack,
  output logic          mcu_ack,
  output logic          mcu_halted,
  output logic          halt_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GNT_CPU   = 3'd1,
    GNT_MCU   = 3'd2,
    HALT_WAIT = 3'd3,
    HALTED    = 3'd4
  } state_t;

  state_t state, state_nxt;
  logic   last_mcu;
  logic   halt_blk;
  logic   tout_hit;
  logic   halt_go;
  logic   enter_cpu, enter_mcu;

  // A timed-out halt request is masked until halt_req has been seen low.
  assign halt_go = halt_req & ~halt_blk;

  always_comb begin
    state_nxt = state;
    if (cen) begin
      case (state)
        IDLE: begin
          if (halt_go)
            state_nxt = HALT_WAIT;
          else if (cpu_cs && mcu_cs)
            state_nxt = last_mcu ? GNT_CPU : GNT_MCU;
          else if (cpu_cs)
            state_nxt = GNT_CPU;
          else if (mcu_cs)
            state_nxt = GNT_MCU;
        end
        GNT_CPU:   state_nxt = mcu_halted ? HALTED : IDLE;
        GNT_MCU:   state_nxt = IDLE;
        HALT_WAIT: begin
          if (!halt_req)
            state_nxt = IDLE;
          else if (mcu_ba)
            state_nxt = HALTED;
          else if (tout_hit)
            state_nxt = IDLE;
        end
        HALTED: begin
          if (!halt_req)
            state_nxt = IDLE;
          else if (cpu_cs)
            state_nxt = GNT_CPU;
        end
        default:   state_nxt = IDLE;
      endcase
    end
  end

  assign enter_cpu = cen && (state != GNT_CPU) && (state_nxt == GNT_CPU);
  assign enter_mcu = cen && (state != GNT_MCU) && (state_nxt == GNT_MCU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_mcu   <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= 8'd0;
      ram_we     <= 1'b0;
      cpu_ack    <= 1'b0;
      mcu_ack    <= 1'b0;
      mcu_halted <= 1'b0;
    end else begin
      state   <= state_nxt;
      ram_we  <= 1'b0;
      cpu_ack <= 1'b0;
      mcu_ack <= 1'b0;
      if (enter_cpu) begin
        ram_addr <= cpu_addr;
        ram_din  <= cpu_din;
        ram_we   <= cpu_we;
      end
      if (enter_mcu) begin
        ram_addr <= mcu_addr;
        ram_din  <= mcu_din;
        ram_we   <= mcu_we;
      end
      // Ack lands in the clk where the 1-clk RAM read data is valid.
      if (cen && state == GNT_CPU) begin
        cpu_ack  <= 1'b1;
        last_mcu <= 1'b0;
      end
      if (cen && state == GNT_MCU) begin
        mcu_ack  <= 1'b1;
        last_mcu <= 1'b1;
      end
      if (cen && state == HALT_WAIT && state_nxt == HALTED)
        mcu_halted <= 1'b1;
      if (cen && state == HALTED && state_nxt == IDLE)
        mcu_halted <= 1'b0;
    end
  end

`ifdef JTDD_ARB_TOUT_EN
  localparam logic [7:0] TOUT_M1 = 8'(TOUT - 1);
  logic [7:0] tcnt;
  logic       tout_fire;

  assign tout_hit  = (tcnt == TOUT_M1);
  assign tout_fire = cen && (state == HALT_WAIT) && halt_req && !mcu_ba && tout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt     <= 8'd0;
      halt_err <= 1'b0;
      halt_blk <= 1'b0;
    end else begin
      if (!halt_req)
        halt_blk <= 1'b0;
      if (cen) begin
        if (state != HALT_WAIT && state_nxt == HALT_WAIT)
          tcnt <= 8'd0;
        else if (state == HALT_WAIT)
          tcnt <= tcnt + 8'd1;
      end
      if (tout_fire) begin
        halt_err <= 1'b1;
        halt_blk <= 1'b1;
      end
    end
  end
`else
  logic unused_tout;
  assign unused_tout = ^8'(TOUT);
  assign tout_hit    = 1'b0;
  assign halt_blk    = 1'b0;
  assign halt_err    = 1'b0;
`endif

endmodule

// File: tb/tb_jtdd_share_arb.sv
// Directed bench for jtdd_share_arb: vector table plus hand-written halt/reset sequences.
module tb_jtdd_share_arb;

`ifdef JTDD_ARB_TOUT_EN
  localparam int TOUT   = 4;
  localparam int HW_CYC = 4;
`else
  localparam int TOUT   = 255;
  localparam int HW_CYC = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       cpu_cs = 1'b0, cpu_we = 1'b0;
  logic [8:0] cpu_addr = '0;
  logic [7:0] cpu_din = '0;
  logic       mcu_cs = 1'b0, mcu_we = 1'b0;
  logic [8:0] mcu_addr = '0;
  logic [7:0] mcu_din = '0;
  logic       halt_req = 1'b0, mcu_ba = 1'b0;
  logic [8:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we, cpu_ack, mcu_ack, mcu_halted, halt_err;

  jtdd_share_arb #(.AW(9), .TOUT(TOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen),
    .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .mcu_cs(mcu_cs), .mcu_we(mcu_we), .mcu_addr(mcu_addr), .mcu_din(mcu_din),
    .halt_req(halt_req), .mcu_ba(mcu_ba),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
    .cpu_ack(cpu_ack), .mcu_ack(mcu_ack), .mcu_halted(mcu_halted), .halt_err(halt_err)
  );

  always #5 clk = ~clk;

  // Shared RAM with one clk of read latency
  logic [7:0] mem [512];
  logic [7:0] q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    q <= mem[ram_addr];
  end

  typedef struct {
    logic       cen, ccs, cwe;
    logic [8:0] caddr;
    logic [7:0] cdin;
    logic       mcs, mwe;
    logic [8:0] maddr;
    logic [7:0] mdin;
    logic       hreq, ba;
    logic       e_we;
    logic [8:0] e_addr;
    logic [7:0] e_din;
    logic       e_cack, e_mack, e_halt, qchk;
    logic [7:0] e_q;
  } vec_t;

  vec_t vecs [20];
  int   nvec = 0;
  int   nerr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic we, input logic [8:0] addr,
                           input logic [7:0] din, input logic ca, input logic ma,
                           input logic hl, input logic er);
    logic [21:0] got, want;
    got  = {ram_we, ram_addr, ram_din, cpu_ack, mcu_ack, mcu_halted, halt_err};
    want = {we, addr, din, ca, ma, hl, er};
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got we=%b addr=%h din=%h cack=%b mack=%b halted=%b err=%b, want we=%b addr=%h din=%h cack=%b mack=%b halted=%b err=%b",
               tag, ram_we, ram_addr, ram_din, cpu_ack, mcu_ack, mcu_halted, halt_err,
               we, addr, din, ca, ma, hl, er);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {cpu_cs, cpu_we, mcu_cs, mcu_we, halt_req, mcu_ba} = '0;
    tick();
    check_out("reset", 0, 9'h000, 8'h00, 0, 0, 0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    //          cen ccs cwe caddr   cdin   mcs mwe maddr   mdin   hr ba  we addr    din    ca ma hl qc q
    vecs[0]  = '{1, 1, 1, 9'h1A5, 8'h5C, 0, 0, 9'h000, 8'h00, 0, 0, 1, 9'h1A5, 8'h5C, 0, 0, 0, 0, 8'h00};
    vecs[1]  = '{1, 1, 1, 9'h1A5, 8'h5C, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h1A5, 8'h5C, 1, 0, 0, 0, 8'h00};
    vecs[2]  = '{1, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h1A5, 8'h5C, 0, 0, 0, 0, 8'h00};
    vecs[3]  = '{1, 1, 0, 9'h1A5, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h1A5, 8'h00, 0, 0, 0, 0, 8'h00};
    vecs[4]  = '{1, 1, 0, 9'h1A5, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h1A5, 8'h00, 1, 0, 0, 1, 8'h5C};
    vecs[5]  = '{1, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h1A5, 8'h00, 0, 0, 0, 0, 8'h00};
    vecs[6]  = '{0, 1, 0, 9'h0AA, 8'h77, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h1A5, 8'h00, 0, 0, 0, 0, 8'h00};
    vecs[7]  = '{0, 0, 0, 9'h0AA, 8'h77, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h1A5, 8'h00, 0, 0, 0, 0, 8'h00};
    vecs[8]  = '{1, 0, 0, 9'h0AA, 8'h77, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h1A5, 8'h00, 0, 0, 0, 0, 8'h00};
    vecs[9]  = '{1, 1, 1, 9'h010, 8'h11, 1, 1, 9'h020, 8'h22, 0, 0, 1, 9'h020, 8'h22, 0, 0, 0, 0, 8'h00};
    vecs[10] = '{1, 1, 1, 9'h010, 8'h11, 1, 1, 9'h020, 8'h22, 0, 0, 0, 9'h020, 8'h22, 0, 1, 0, 0, 8'h00};
    vecs[11] = '{1, 1, 1, 9'h010, 8'h11, 1, 1, 9'h020, 8'h22, 0, 0, 1, 9'h010, 8'h11, 0, 0, 0, 0, 8'h00};
    vecs[12] = '{1, 1, 1, 9'h010, 8'h11, 1, 1, 9'h020, 8'h22, 0, 0, 0, 9'h010, 8'h11, 1, 0, 0, 0, 8'h00};
    vecs[13] = '{1, 1, 1, 9'h010, 8'h11, 1, 1, 9'h020, 8'h22, 0, 0, 1, 9'h020, 8'h22, 0, 0, 0, 0, 8'h00};
    vecs[14] = '{1, 1, 1, 9'h010, 8'h11, 1, 1, 9'h020, 8'h22, 0, 0, 0, 9'h020, 8'h22, 0, 1, 0, 0, 8'h00};
    vecs[15] = '{1, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h020, 8'h22, 0, 0, 0, 0, 8'h00};
    vecs[16] = '{1, 1, 1, 9'h033, 8'h44, 0, 0, 9'h000, 8'h00, 0, 0, 1, 9'h033, 8'h44, 0, 0, 0, 0, 8'h00};
    vecs[17] = '{0, 1, 1, 9'h033, 8'h44, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h033, 8'h44, 0, 0, 0, 0, 8'h00};
    vecs[18] = '{1, 1, 1, 9'h033, 8'h44, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h033, 8'h44, 1, 0, 0, 0, 8'h00};
    vecs[19] = '{0, 0, 0, 9'h000, 8'h00, 0, 0, 9'h000, 8'h00, 0, 0, 0, 9'h033, 8'h44, 0, 0, 0, 0, 8'h00};

    #2;
    do_reset();

    for (int i = 0; i < 20; i++) begin
      cen = vecs[i].cen;
      cpu_cs = vecs[i].ccs; cpu_we = vecs[i].cwe; cpu_addr = vecs[i].caddr; cpu_din = vecs[i].cdin;
      mcu_cs = vecs[i].mcs; mcu_we = vecs[i].mwe; mcu_addr = vecs[i].maddr; mcu_din = vecs[i].mdin;
      halt_req = vecs[i].hreq; mcu_ba = vecs[i].ba;
      tick();
      check_out($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_addr, vecs[i].e_din,
                vecs[i].e_cack, vecs[i].e_mack, vecs[i].e_halt, 1'b0);
      if (vecs[i].qchk) begin
        nvec++;
        if (q !== vecs[i].e_q) begin
          nerr++;
          $display("FAIL vec%0d_q: got %h want %h", i, q, vecs[i].e_q);
        end
      end
    end

    // Halt handshake: MCU request pending throughout, never served while halted
    cen = 1'b1; cpu_cs = 1'b0;
    mcu_cs = 1'b1; mcu_we = 1'b0; mcu_addr = 9'h0C3; mcu_din = 8'h99;
    halt_req = 1'b1; mcu_ba = 1'b0;
    for (int i = 1; i <= HW_CYC; i++) begin
      tick();
      check_out($sformatf("halt_wait%0d", i), 0, 9'h033, 8'h44, 0, 0, 0, 0);
    end
    mcu_ba = 1'b1;
    tick();
    check_out("halted_rise", 0, 9'h033, 8'h44, 0, 0, 1, 0);
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h055; cpu_din = 8'h66;
    tick();
    check_out("halted_gnt_cpu", 1, 9'h055, 8'h66, 0, 0, 1, 0);
    tick();
    check_out("halted_cpu_ack", 0, 9'h055, 8'h66, 1, 0, 1, 0);
    cpu_cs = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("halted_hold%0d", i), 0, 9'h055, 8'h66, 0, 0, 1, 0);
    end
    halt_req = 1'b0; mcu_ba = 1'b0;
    tick();
    check_out("halt_release", 0, 9'h055, 8'h66, 0, 0, 0, 0);
    tick();
    check_out("mcu_gnt_after_halt", 0, 9'h0C3, 8'h99, 0, 0, 0, 0);
    tick();
    check_out("mcu_ack_after_halt", 0, 9'h0C3, 8'h99, 0, 1, 0, 0);
    mcu_cs = 1'b0;

    // Round-robin from reset: MCU first, then alternate
    do_reset();
    cen = 1'b1;
    cpu_cs = 1'b1; cpu_we = 1'b1; cpu_addr = 9'h101; cpu_din = 8'h10;
    mcu_cs = 1'b1; mcu_we = 1'b1; mcu_addr = 9'h102; mcu_din = 8'h20;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k % 2 == 0) check_out($sformatf("rr_gnt%0d", k), 1, 9'h102, 8'h20, 0, 0, 0, 0);
      else            check_out($sformatf("rr_gnt%0d", k), 1, 9'h101, 8'h10, 0, 0, 0, 0);
      tick();
      if (k % 2 == 0) check_out($sformatf("rr_ack%0d", k), 0, 9'h102, 8'h20, 0, 1, 0, 0);
      else            check_out($sformatf("rr_ack%0d", k), 0, 9'h101, 8'h10, 1, 0, 0, 0);
    end
    cpu_cs = 1'b0; mcu_cs = 1'b0;
    tick();

    // Reset in the middle of an MCU grant
    mcu_cs = 1'b1; mcu_we = 1'b1; mcu_addr = 9'h1FF; mcu_din = 8'hAB;
    tick();
    check_out("abort_gnt", 1, 9'h1FF, 8'hAB, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_out("abort_async", 0, 9'h000, 8'h00, 0, 0, 0, 0);
    mcu_cs = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_out($sformatf("abort_noack%0d", i), 0, 9'h000, 8'h00, 0, 0, 0, 0);
    end

`ifdef JTDD_ARB_TOUT_EN
    // Halt timeout: sticky error, halt_req masked until seen low
    halt_req = 1'b1; mcu_ba = 1'b0;
    tick();
    check_out("tout_entry", 0, 9'h000, 8'h00, 0, 0, 0, 0);
    for (int i = 1; i < TOUT; i++) begin
      tick();
      check_out($sformatf("tout_wait%0d", i), 0, 9'h000, 8'h00, 0, 0, 0, 0);
    end
    tick();
    check_out("tout_fire", 0, 9'h000, 8'h00, 0, 0, 0, 1);
    cpu_cs = 1'b1; cpu_we = 1'b0; cpu_addr = 9'h007; cpu_din = 8'h00;
    tick();
    check_out("tout_idle_gnt", 0, 9'h007, 8'h00, 0, 0, 0, 1);
    tick();
    check_out("tout_idle_ack", 0, 9'h007, 8'h00, 1, 0, 0, 1);
    cpu_cs = 1'b0;
    halt_req = 1'b0;
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    check_out("tout_sticky", 0, 9'h007, 8'h00, 0, 0, 0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/jtdd_share_arb.md
JTDD_SHARE_ARB -- requirements
Module: jtdd_share_arb

Interface
REQ-001 Parameter AW, default 9: shared RAM address width.
REQ-002 Parameter TOUT, default 255: HALT_WAIT timeout, in cen cycles (used only under REQ-034).
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 cen  in  1  arbitration clock enable; state advances only when high.
REQ-006 cpu_cs, cpu_we  in  1 each  main CPU access request and write strobe; level-held until cpu_ack.
REQ-007 cpu_addr  in  AW; cpu_din  in  8  main CPU address and write data.
REQ-008 mcu_cs, mcu_we  in  1 each; mcu_addr  in  AW; mcu_din  in  8  MCU request, same rules as the CPU.
REQ-009 halt_req  in  1  main CPU request to halt the MCU.
REQ-010 mcu_ba  in  1  MCU bus-available; high when the MCU can be stopped.
REQ-011 ram_addr  out  AW; ram_din  out  8; ram_we  out  1  shared RAM port (RAM read latency 1 clk).
REQ-012 cpu_ack, mcu_ack  out  1 each  one-clk pulse; RAM q valid in the same clk.
REQ-013 mcu_halted  out  1  high while the MCU is halted; gates the MCU clock enable.
REQ-014 halt_err  out  1  sticky timeout flag.

Function
REQ-015 FSM states: IDLE, GNT_CPU, GNT_MCU, HALT_WAIT, HALTED.
REQ-016 IDLE, cen=1, priority: halt_req -> HALT_WAIT; else a single pending requester -> its GNT state; else stay.
REQ-017 Simultaneous cpu_cs and mcu_cs in IDLE: grant the requester not granted last (round-robin bit, reset value CPU-last so the MCU wins first).
REQ-018 GNT_x lasts exactly one cen cycle: ram_addr/ram_din from that requester, ram_we = x_we; then IDLE.
REQ-019 x_ack pulses for one clk on the first clk after leaving GNT_x; the round-robin bit updates at the same time.
REQ-020 Back-to-back accesses from one requester: minimum 2 cen cycles per access.
REQ-021 A request dropped before grant is discarded; no ack.
REQ-022 Outside GNT states ram_we = 0; ram_addr/ram_din hold the last driven value.
REQ-023 HALT_WAIT: when mcu_ba = 1 on a cen cycle -> HALTED; mcu_halted rises in the same clk as the transition.
REQ-024 HALT_WAIT or HALTED with halt_req = 0 on a cen cycle -> IDLE; mcu_halted falls in the same clk.
REQ-025 HALTED: only CPU requests are served, as HALTED -> GNT_CPU -> HALTED, with ack per REQ-019; mcu_cs is ignored and mcu_ack is never asserted.
REQ-026 In HALT_WAIT, CPU and MCU requests are not granted.
REQ-027 halt_req rising while in a GNT state: the grant completes first, then IDLE -> HALT_WAIT.
REQ-028 cen = 0: no state change, no new ram_we; ack pulses already scheduled still occur.

Reset
REQ-029 rst_n low: state IDLE; round-robin bit CPU-last; all outputs 0; timeout counter 0.
REQ-030 Reset asserted mid-grant aborts the access with no ack; RAM contents are not a reset concern.
REQ-031 Release of rst_n is synchronous to clk; the first transition is possible on the first cen after release.

Configuration
REQ-032 Macro JTDD_ARB_TOUT_EN.
REQ-033 Without the macro: HALT_WAIT waits indefinitely; halt_err is tied 0.
REQ-034 With the macro:
  - an 8-bit counter clears on entry to HALT_WAIT and counts cen cycles there;
  - on reaching TOUT: set halt_err, go to IDLE, ignore halt_req until it is seen low once;
  - halt_err clears only on reset.

Verification
REQ-035 cpu_cs=1, we=1, addr=0x1A5, din=0x5C; then read 0x1A5 -> ram_we one clk, cpu_ack one clk later, read ack with q=0x5C.
REQ-036 cpu_cs and mcu_cs asserted together from reset, held -> grants alternate MCU, CPU, MCU, CPU; exactly one ack per grant.
REQ-037 halt_req=1, mcu_ba=0 for 10 cen, then 1 -> mcu_halted rises on the 11th cen; mcu_cs is never acked while halted; cpu_cs is acked.
REQ-038 halt_req dropped in HALTED -> mcu_halted low next cen; a pending mcu_cs is granted within 2 cen.
REQ-039 With JTDD_ARB_TOUT_EN, TOUT=4, mcu_ba=0 -> halt_err=1 after 4 cen; state IDLE; halt_err survives halt_req toggling.
REQ-040 rst_n pulsed low during GNT_MCU -> no mcu_ack; all outputs 0 immediately and asynchronously.
